// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and fetch-side run control.
// Optional target alignment check enabled by defining IF_PC_ALIGN_CHECK_EN.
module if_pc_stage #(
  parameter int unsigned           NB_PC      = 32,
  parameter int unsigned           NB_INSTR   = 32,
  parameter logic [NB_PC-1:0]      RESET_PC   = '0,
  parameter logic [NB_INSTR-1:0]   HALT_INSTR = NB_INSTR'(32'hFFFF_FFFF),
  parameter logic [NB_INSTR-1:0]   NOP_INSTR  = NB_INSTR'(32'h0000_0013)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NB_PC-1:0]    i_next_pc,
  input  logic [NB_INSTR-1:0] i_instr,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_run,
  input  logic                i_step,
  output logic [NB_PC-1:0]    o_pc,
  output logic [NB_PC-1:0]    o_pc_plus4,
  output logic [NB_PC-1:0]    o_ifid_pc,
  output logic [NB_INSTR-1:0] o_ifid_instr,
  output logic                o_ifid_valid,
  output logic                o_halted,
  output logic [1:0]          o_state,
  output logic [31:0]         o_instr_count,
  output logic                o_misaligned
);

  localparam int unsigned NB_CNT = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [NB_PC-1:0]    pc_q;
  logic [NB_PC-1:0]    ifid_pc_q;
  logic [NB_INSTR-1:0] ifid_instr_q;
  logic                ifid_valid_q;
  logic                halted_q;
  logic [NB_CNT-1:0]   count_q;
  logic                mis_q;

  logic adv;
  logic halt_hit;
  logic mis_hit;
  logic pc_load;
  logic commit;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a halt or a rejected target always wins
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          state_d = ST_RUN;
        end else if (i_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_hit || mis_hit) begin
          state_d = ST_HALTED;
        end else if (!i_run) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_hit || mis_hit) begin
          state_d = ST_HALTED;
        end else if (adv) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Fetch control decode; flush overrides stall and suppresses the halt check
  always_comb begin
    adv      = 1'b0;
    halt_hit = 1'b0;
    mis_hit  = 1'b0;
    pc_load  = 1'b0;
    commit   = 1'b0;
    adv      = ((state_q == ST_RUN) || (state_q == ST_STEP)) && (!i_stall || i_flush);
    halt_hit = adv && !i_flush && (i_instr == HALT_INSTR);
`ifdef IF_PC_ALIGN_CHECK_EN
    mis_hit  = adv && !halt_hit && (i_next_pc[1:0] != 2'b00);
`endif
    pc_load  = adv && !halt_hit && !mis_hit;
    commit   = adv && !i_flush;
  end

  // PC and IF/ID pipeline register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      if (pc_load) begin
        pc_q <= i_next_pc;
      end
      if (adv) begin
        ifid_pc_q    <= pc_q;
        ifid_instr_q <= i_flush ? NOP_INSTR : i_instr;
        ifid_valid_q <= !i_flush;
      end
    end
  end

  // Saturating commit counter and sticky status flags
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      if (commit && (count_q != '1)) begin
        count_q <= count_q + NB_CNT'(1);
      end
      halted_q <= (state_d == ST_HALTED);
      if (mis_hit) begin
        mis_q <= 1'b1;
      end
    end
  end

  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_q + NB_PC'(4);
  assign o_ifid_pc     = ifid_pc_q;
  assign o_ifid_instr  = ifid_instr_q;
  assign o_ifid_valid  = ifid_valid_q;
  assign o_halted      = halted_q;
  assign o_state       = state_q;
  assign o_instr_count = count_q;
`ifdef IF_PC_ALIGN_CHECK_EN
  assign o_misaligned  = mis_q;
`else
  assign o_misaligned  = 1'b0;
`endif

endmodule

// File: tb/tb_if_pc_stage.sv
// Bench for if_pc_stage: directed vector table followed by randomized run against a reference model.
module tb_if_pc_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, run, step, stall, flush;
  logic        np_sel, ins_sel;
  logic [31:0] np_val, ins_val;
  logic [31:0] next_pc, instr;
  logic [31:0] pc, pc_plus4, ifid_pc, ifid_instr, instr_count;
  logic        ifid_valid, halted, misaligned;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a + 32'h0000_1000;
  endfunction

  assign next_pc = np_sel ? np_val : pc_plus4;
  assign instr   = ins_sel ? ins_val : imem(pc);

  if_pc_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_next_pc(next_pc), .i_instr(instr),
    .i_stall(stall), .i_flush(flush), .i_run(run), .i_step(step),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .o_ifid_pc(ifid_pc), .o_ifid_instr(ifid_instr),
    .o_ifid_valid(ifid_valid), .o_halted(halted), .o_state(state),
    .o_instr_count(instr_count), .o_misaligned(misaligned)
  );

  // Reference model: mode 0 idle, 1 run, 2 step, 3 halted
  logic [31:0] m_pc, m_ipc, m_ins, m_cnt;
  logic        m_v, m_mis;
  int          m_mode;

  task automatic model_step();
    logic [31:0] f_ins, f_np;
    bit fetch, is_halt, bad;
    f_ins = ins_sel ? ins_val : imem(m_pc);
    f_np  = np_sel ? np_val : m_pc + 32'd4;
    if (!rst_n) begin
      m_pc = 0; m_ipc = 0; m_ins = NOP; m_v = 0; m_mode = 0; m_cnt = 0; m_mis = 0;
      return;
    end
    fetch   = (m_mode == 1 || m_mode == 2) && (!stall || flush);
    is_halt = fetch && !flush && f_ins == HALT;
    bad     = 0;
`ifdef IF_PC_ALIGN_CHECK_EN
    bad = fetch && !is_halt && f_np[1:0] != 2'b00;
`endif
    if (fetch) begin
      m_ipc = m_pc;
      if (flush) begin
        m_ins = NOP; m_v = 0;
      end else begin
        m_ins = f_ins; m_v = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end
      if (!is_halt && !bad) m_pc = f_np;
      if (bad) m_mis = 1;
    end
    if (is_halt || bad) m_mode = 3;
    else if (m_mode == 0) m_mode = run ? 1 : (step ? 2 : 0);
    else if (m_mode == 1) m_mode = run ? 1 : 0;
    else if (m_mode == 2) m_mode = fetch ? 0 : 2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst_n, run, step, stall, flush, np_sel;
    logic [31:0] np_val;
    logic ins_sel;
    logic [31:0] ins_val;
    logic [31:0] e_pc, e_ipc, e_ins;
    logic e_v;
    logic [1:0] e_st;
    logic [31:0] e_cnt;
    logic e_mis;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic ru, input logic s, input logic sl, input logic f,
                     input logic ns, input logic [31:0] nv, input logic is, input logic [31:0] iv,
                     input logic [31:0] ep, input logic [31:0] eip, input logic [31:0] ei,
                     input logic ev, input logic [1:0] es, input logic [31:0] ec, input logic em);
    vec_t v;
    v.rst_n = r; v.run = ru; v.step = s; v.stall = sl; v.flush = f; v.np_sel = ns;
    v.np_val = nv; v.ins_sel = is; v.ins_val = iv; v.e_pc = ep; v.e_ipc = eip;
    v.e_ins = ei; v.e_v = ev; v.e_st = es; v.e_cnt = ec; v.e_mis = em;
    tv.push_back(v);
  endtask

  initial begin
    rst_n = 0; run = 0; step = 0; stall = 0; flush = 0;
    np_sel = 0; np_val = 0; ins_sel = 0; ins_val = 0;

    //  rst run stp stl fl  ns  np      is  ins   pc     ipc    ins         v  st cnt mis
    add(0, 0, 0, 0, 0, 0, 0,     0, 0,    32'h0,  32'h0,  NOP,        0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,     0, 0,    32'h0,  32'h0,  NOP,        0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,     0, 0,    32'h4,  32'h0,  32'h1000,   1, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0,     0, 0,    32'h8,  32'h4,  32'h1004,   1, 1, 2, 0);
    add(1, 1, 0, 1, 0, 0, 0,     0, 0,    32'h8,  32'h4,  32'h1004,   1, 1, 2, 0);
    add(1, 1, 0, 1, 0, 0, 0,     0, 0,    32'h8,  32'h4,  32'h1004,   1, 1, 2, 0);
    add(1, 1, 0, 0, 0, 0, 0,     0, 0,    32'hC,  32'h8,  32'h1008,   1, 1, 3, 0);
    add(1, 1, 0, 0, 0, 0, 0,     0, 0,    32'h10, 32'hC,  32'h100C,   1, 1, 4, 0);
    add(1, 1, 0, 1, 1, 1, 32'h40, 0, 0,   32'h40, 32'h10, NOP,        0, 1, 4, 0);
    add(1, 0, 0, 0, 0, 0, 0,     0, 0,    32'h44, 32'h40, 32'h1040,   1, 0, 5, 0);
    add(1, 0, 1, 1, 0, 0, 0,     0, 0,    32'h44, 32'h40, 32'h1040,   1, 2, 5, 0);
    add(1, 0, 0, 1, 0, 0, 0,     0, 0,    32'h44, 32'h40, 32'h1040,   1, 2, 5, 0);
    add(1, 0, 0, 1, 0, 0, 0,     0, 0,    32'h44, 32'h40, 32'h1040,   1, 2, 5, 0);
    add(1, 0, 0, 1, 0, 0, 0,     0, 0,    32'h44, 32'h40, 32'h1040,   1, 2, 5, 0);
    add(1, 0, 0, 0, 0, 0, 0,     0, 0,    32'h48, 32'h44, 32'h1044,   1, 0, 6, 0);
    add(1, 0, 0, 0, 0, 0, 0,     0, 0,    32'h48, 32'h44, 32'h1044,   1, 0, 6, 0);
    add(1, 1, 0, 0, 0, 1, 32'h20, 0, 0,   32'h48, 32'h44, 32'h1044,   1, 1, 6, 0);
    add(1, 1, 0, 0, 0, 1, 32'h20, 0, 0,   32'h20, 32'h48, 32'h1048,   1, 1, 7, 0);
    add(1, 1, 0, 0, 0, 0, 0,     1, HALT, 32'h20, 32'h20, HALT,       1, 3, 8, 0);
    add(1, 1, 1, 0, 0, 0, 0,     0, 0,    32'h20, 32'h20, HALT,       1, 3, 8, 0);
    add(0, 1, 0, 0, 0, 0, 0,     0, 0,    32'h0,  32'h0,  NOP,        0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,     0, 0,    32'h0,  32'h0,  NOP,        0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 32'h22, 0, 0,   32'h0,  32'h0,  NOP,        0, 1, 0, 0);
`ifdef IF_PC_ALIGN_CHECK_EN
    add(1, 1, 0, 0, 0, 1, 32'h22, 0, 0,   32'h0,  32'h0,  32'h1000,   1, 3, 1, 1);
`else
    add(1, 1, 0, 0, 0, 1, 32'h22, 0, 0,   32'h22, 32'h0,  32'h1000,   1, 1, 1, 0);
`endif
    add(0, 0, 0, 0, 0, 0, 0,     0, 0,    32'h0,  32'h0,  NOP,        0, 0, 0, 0);

    #2;
    foreach (tv[i]) begin
      rst_n = tv[i].rst_n; run = tv[i].run; step = tv[i].step; stall = tv[i].stall;
      flush = tv[i].flush; np_sel = tv[i].np_sel; np_val = tv[i].np_val;
      ins_sel = tv[i].ins_sel; ins_val = tv[i].ins_val;
      cycle();
      check($sformatf("v%0d pc", i),       pc,                 tv[i].e_pc);
      check($sformatf("v%0d pc_plus4", i), pc_plus4,           tv[i].e_pc + 32'd4);
      check($sformatf("v%0d ifid_pc", i),  ifid_pc,            tv[i].e_ipc);
      check($sformatf("v%0d ifid_ins", i), ifid_instr,         tv[i].e_ins);
      check($sformatf("v%0d valid", i),    32'(ifid_valid),    32'(tv[i].e_v));
      check($sformatf("v%0d state", i),    32'(state),         32'(tv[i].e_st));
      check($sformatf("v%0d halted", i),   32'(halted),        32'(tv[i].e_st == 2'd3));
      check($sformatf("v%0d count", i),    instr_count,        tv[i].e_cnt);
      check($sformatf("v%0d misalign", i), 32'(misaligned),    32'(tv[i].e_mis));
    end

    for (int c = 0; c < 3000; c++) begin
      rst_n   = (m_mode == 3) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 199) != 0);
      run     = ($urandom_range(0, 9) < 8);
      step    = ($urandom_range(0, 3) == 0);
      stall   = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      np_sel  = ($urandom_range(0, 5) == 0);
      np_val  = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 15) == 0) np_val[1:0] = 2'($urandom_range(1, 3));
      ins_sel = ($urandom_range(0, 39) == 0);
      ins_val = ($urandom_range(0, 3) == 0) ? 32'($urandom) : HALT;
      cycle();
      check("rnd pc",       pc,              m_pc);
      check("rnd pc_plus4", pc_plus4,        m_pc + 32'd4);
      check("rnd ifid_pc",  ifid_pc,         m_ipc);
      check("rnd ifid_ins", ifid_instr,      m_ins);
      check("rnd valid",    32'(ifid_valid), 32'(m_v));
      check("rnd state",    32'(state),      32'(m_mode));
      check("rnd halted",   32'(halted),     32'(m_mode == 3));
      check("rnd count",    instr_count,     m_cnt);
      check("rnd misalign", 32'(misaligned), 32'(m_mis));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
